// File: rtl/factor_engine.sv
// Trial-division factoriser: finds the smallest prime factor and cofactor of an
// unsigned operand using repeated subtraction and an incrementally tracked d*d bound.
module factor_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] number,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] factor,
  output logic [WIDTH-1:0] cofactor,
  output logic             is_prime
);

  localparam int SQW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    TRIAL,
    FINISH
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [SQW-1:0]   sq_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] factor_q;
  logic [WIDTH-1:0] cofactor_q;
  logic             isPrime_q;

  logic [SQW-1:0]   sq_d;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] d_d;
  logic             sqOver;
  logic             rGeD;
  logic             rZero;

  // (d+1)^2 = d^2 + 2d + 1, where {d,1} is exactly 2d+1 in the wider sq width
  assign sq_d   = sq_q + {{WIDTH{1'b0}}, d_q, 1'b1};
  assign r_d    = r_q - d_q;
  assign q_d    = q_q + WIDTH'(1);
  assign d_d    = d_q + WIDTH'(1);
  assign sqOver = sq_q > {{(WIDTH + 1){1'b0}}, n_q};
  assign rGeD   = r_q >= d_q;
  assign rZero  = r_q == '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      n_q        <= '0;
      d_q        <= '0;
      r_q        <= '0;
      q_q        <= '0;
      sq_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      factor_q   <= '0;
      cofactor_q <= '0;
      isPrime_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            if (number < WIDTH'(2)) begin
              // 0 and 1 have no prime factor; report the operand itself
              factor_q   <= number;
              cofactor_q <= number;
              isPrime_q  <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= FINISH;
            end else begin
              n_q     <= number;
              d_q     <= WIDTH'(2);
              r_q     <= number;
              q_q     <= '0;
              sq_q    <= SQW'(4);
              busy_q  <= 1'b1;
              state_q <= TRIAL;
            end
          end
        end
        TRIAL: begin
          if (sqOver) begin
            factor_q   <= n_q;
            cofactor_q <= WIDTH'(1);
            isPrime_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= FINISH;
          end else if (rGeD) begin
            r_q <= r_d;
            q_q <= q_d;
          end else if (rZero) begin
            factor_q   <= d_q;
            cofactor_q <= q_q;
            isPrime_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= FINISH;
          end else begin
            // d does not divide n: move to the next candidate and restart the division
            d_q  <= d_d;
            sq_q <= sq_d;
            r_q  <= n_q;
            q_q  <= '0;
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign factor   = factor_q;
  assign cofactor = cofactor_q;
  assign is_prime = isPrime_q;

endmodule

// File: tb/tb_factor_engine.sv
// Self-checking bench for factor_engine: directed scenarios, a full 0..255 sweep and
// randomized operands, all compared against an arithmetic reference model.
module tb_factor_engine;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] number;
  logic       busy;
  logic       done;
  logic [7:0] factor;
  logic [7:0] cofactor;
  logic       is_prime;

  int checks = 0;
  int errors = 0;

  logic [7:0] heldFactor   = '0;
  logic [7:0] heldCofactor = '0;
  logic       heldPrime    = 1'b0;

  factor_engine #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .number   (number),
    .busy     (busy),
    .done     (done),
    .factor   (factor),
    .cofactor (cofactor),
    .is_prime (is_prime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: smallest divisor by modulo search; latency from the trial rules
  // (each rejected d costs n/d subtractions plus one step, the winning d costs n/d + 1,
  // a prime costs one extra cycle for the bound check).
  function automatic void refModel(input int n, output int f, output int c,
                                   output bit p, output int cyc);
    int sd;
    f = n; c = n; p = 1'b0; cyc = 0;
    if (n < 2) return;
    sd = 2;
    while (n % sd != 0) sd++;
    if (sd == n) begin
      f = n; c = 1; p = 1'b1;
      for (int d = 2; d * d <= n; d++) cyc += n / d + 1;
      cyc += 1;
    end else begin
      f = sd; c = n / sd; p = 1'b0;
      for (int d = 2; d < sd; d++) cyc += n / d + 1;
      cyc += n / sd + 1;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Accept one operand, wait (bounded) for done, return observed trial cycles
  task automatic applyStimulus(input logic [7:0] n, output int cyc, output bit busyOk);
    start  = 1'b1;
    number = n;
    tick(1);
    start  = 1'b0;
    number = 8'($urandom);
    busyOk = (busy === (n >= 8'd2));
    cyc    = 0;
    while (done !== 1'b1 && cyc < 2048) begin
      if (busy !== 1'b1) busyOk = 1'b0;
      tick(1);
      cyc++;
    end
  endtask

  task automatic runCase(input logic [7:0] n, input string tag);
    int expF, expC, expCyc, cyc;
    bit expP, busyOk;
    checkOutput({tag, ".heldFactor"}, factor, heldFactor);
    checkOutput({tag, ".heldCofactor"}, cofactor, heldCofactor);
    checkOutput({tag, ".heldPrime"}, is_prime, heldPrime);
    refModel(n, expF, expC, expP, expCyc);
    applyStimulus(n, cyc, busyOk);
    checkOutput({tag, ".done"}, done, 1);
    checkOutput({tag, ".cycles"}, cyc, expCyc);
    checkOutput({tag, ".busyWindow"}, busyOk, 1);
    checkOutput({tag, ".busyAtDone"}, busy, 0);
    checkOutput({tag, ".factor"}, factor, expF);
    checkOutput({tag, ".cofactor"}, cofactor, expC);
    checkOutput({tag, ".isPrime"}, is_prime, expP);
    heldFactor   = 8'(expF);
    heldCofactor = 8'(expC);
    heldPrime    = expP;
    tick(1);
    checkOutput({tag, ".donePulse"}, done, 0);
  endtask

  initial begin
    int cyc, doneCount, expF, expC, expCyc;
    bit expP;
    logic [7:0] rn;

    reset  = 1'b1;
    start  = 1'b0;
    number = '0;
    tick(2);
    checkOutput("reset.outputs", {busy, done, factor, cofactor, is_prime}, 0);
    reset = 1'b0;
    tick(1);

    runCase(8'd6, "six");
    runCase(8'd91, "n91");
    runCase(8'd221, "n221");
    runCase(8'd4, "n4");
    runCase(8'd251, "n251");
    runCase(8'd2, "n2");
    runCase(8'd0, "n0");
    runCase(8'd1, "n1");

    // Held start: the second run begins in the IDLE cycle after FINISH
    start  = 1'b1;
    number = 8'd91;
    tick(1);
    number = 8'd97;
    cyc = 0;
    while (done !== 1'b1 && cyc < 2048) begin
      tick(1);
      cyc++;
    end
    checkOutput("held.first.done", done, 1);
    checkOutput("held.first.factor", factor, 7);
    checkOutput("held.first.cofactor", cofactor, 13);
    checkOutput("held.first.isPrime", is_prime, 0);
    tick(1);
    checkOutput("held.idle.done", done, 0);
    checkOutput("held.idle.busy", busy, 0);
    tick(1);
    checkOutput("held.second.busy", busy, 1);
    start = 1'b0;
    refModel(97, expF, expC, expP, expCyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 2048) begin
      tick(1);
      cyc++;
    end
    checkOutput("held.second.cycles", cyc, expCyc);
    checkOutput("held.second.factor", factor, 97);
    checkOutput("held.second.cofactor", cofactor, 1);
    checkOutput("held.second.isPrime", is_prime, 1);
    doneCount = 0;
    repeat (6) begin
      tick(1);
      if (done === 1'b1) doneCount++;
    end
    checkOutput("held.extraDone", doneCount, 0);
    heldFactor   = 8'd97;
    heldCofactor = 8'd1;
    heldPrime    = 1'b1;

    // Reset in the middle of a search clears everything and suppresses done
    start  = 1'b1;
    number = 8'd221;
    tick(1);
    start = 1'b0;
    tick(5);
    reset = 1'b1;
    tick(1);
    checkOutput("abort.outputs", {busy, done, factor, cofactor, is_prime}, 0);
    reset = 1'b0;
    doneCount = 0;
    repeat (10) begin
      tick(1);
      if (done === 1'b1) doneCount++;
    end
    checkOutput("abort.noDone", doneCount, 0);
    heldFactor   = '0;
    heldCofactor = '0;
    heldPrime    = 1'b0;
    runCase(8'd15, "after.abort");

    for (int i = 0; i < 256; i++) begin
      runCase(8'(i), $sformatf("sweep%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      rn = 8'($urandom_range(0, 255));
      tick($urandom_range(0, 3));
      runCase(rn, $sformatf("rand%0d_n%0d", i, rn));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
